// File: rtl/cache_pkg.sv
// Shared constants for the direct-mapped write-through cache: default sizes,
// derived field widths and address bit positions.
package cache_pkg;

    localparam int ADDR_W        = 32;
    localparam int DATA_W        = 32;
    localparam int NUM_LINES_DEF = 16;
    localparam int MEM_WORDS_DEF = 1024;
    localparam int WORD_LSB      = 2;
    localparam int INDEX_LSB     = WORD_LSB;
    localparam int INDEX_W_DEF   = $clog2(NUM_LINES_DEF);
    localparam int TAG_LSB_DEF   = INDEX_LSB + INDEX_W_DEF;
    localparam int TAG_W_DEF     = ADDR_W - TAG_LSB_DEF;
    localparam int MEM_AW_DEF    = $clog2(MEM_WORDS_DEF);

    // Tag width for an arbitrary line count; everything above the index is tag.
    function automatic int tag_width(input int lines);
        return ADDR_W - INDEX_LSB - $clog2(lines);
    endfunction

endpackage

// File: rtl/cache_mem.sv
// Backing word memory: one synchronous write port, one combinational read port.
// Contents are deliberately not reset.
module cache_mem
    import cache_pkg::*;
#(
    parameter int MEM_WORDS = MEM_WORDS_DEF,
    parameter int MEM_AW    = $clog2(MEM_WORDS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [MEM_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [MEM_AW-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [MEM_WORDS];

    // Word write on the rising edge when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/cache.sv
// Direct-mapped, one-word-per-line, write-through / write-allocate cache with
// one-cycle read latency in front of cache_mem.
module cache
    import cache_pkg::*;
#(
    parameter int NUM_LINES = NUM_LINES_DEF,
    parameter int MEM_WORDS = MEM_WORDS_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MWR,
    input  logic        MOE,
    input  logic [31:0] Adr,
    input  logic [31:0] MWD,
    output logic [31:0] CRD,
    output logic        CHIT
);

    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int TAG_W  = tag_width(NUM_LINES);
    localparam int MEM_AW = $clog2(MEM_WORDS);

    logic [IDX_W-1:0]     idx_s;
    logic [TAG_W-1:0]     tag_s;
    logic [MEM_AW-1:0]    maddr_s;
    logic [DATA_W-1:0]    mem_rdata_s;
    logic [DATA_W-1:0]    fill_s;
    logic                 hit_s;
    logic                 mem_we_s;
    logic                 unused_s;

    logic [NUM_LINES-1:0] valid_r;
    logic [TAG_W-1:0]     tag_r  [NUM_LINES];
    logic [DATA_W-1:0]    data_r [NUM_LINES];
    logic [DATA_W-1:0]    crd_r;
    logic                 chit_r;

    // Address decode, hit detection and the word that a line would be filled with.
    always_comb begin
        idx_s    = Adr[INDEX_LSB +: IDX_W];
        tag_s    = Adr[ADDR_W-1 -: TAG_W];
        maddr_s  = Adr[WORD_LSB +: MEM_AW];
        hit_s    = valid_r[idx_s] && (tag_r[idx_s] == tag_s);
        mem_we_s = MWR && !rst;
        if (MWR) begin
            fill_s = MWD;
        end else if (hit_s) begin
            fill_s = data_r[idx_s];
        end else begin
            fill_s = mem_rdata_s;
        end
    end

    // Byte offset within the word is intentionally ignored.
    assign unused_s = ^Adr[WORD_LSB-1:0];

    cache_mem #(
        .MEM_WORDS (MEM_WORDS),
        .MEM_AW    (MEM_AW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we_s),
        .waddr (maddr_s),
        .wdata (MWD),
        .raddr (maddr_s),
        .rdata (mem_rdata_s)
    );

    // Valid bits and output registers; reset only invalidates, arrays keep contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= '0;
            crd_r   <= 32'h0000_0000;
            chit_r  <= 1'b0;
        end else if (MWR) begin
            valid_r[idx_s] <= 1'b1;
            chit_r         <= 1'b0;
        end else if (MOE) begin
            valid_r[idx_s] <= 1'b1;
            crd_r          <= fill_s;
            chit_r         <= hit_s;
        end else begin
            chit_r <= 1'b0;
        end
    end

    // Tag/data arrays: allocate on every write, fill on every read (hit rewrites itself).
    always_ff @(posedge clk) begin
        if (!rst && (MWR || MOE)) begin
            tag_r[idx_s]  <= tag_s;
            data_r[idx_s] <= fill_s;
        end
    end

    assign CRD  = crd_r;
    assign CHIT = chit_r;

endmodule

// File: tb/tb_cache.sv
// Self-checking bench for cache: directed vector table plus randomized traffic
// compared against an address-arithmetic reference model.
module tb_cache;

    localparam int NL = 16;
    localparam int MW = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        MWR = 1'b0;
    logic        MOE = 1'b0;
    logic [31:0] Adr = 32'h0;
    logic [31:0] MWD = 32'h0;
    logic [31:0] CRD;
    logic        CHIT;

    int checks = 0;
    int passes = 0;

    cache #(.NUM_LINES(NL), .MEM_WORDS(MW)) dut (
        .clk (clk), .rst (rst), .MWR (MWR), .MOE (MOE),
        .Adr (Adr), .MWD (MWD), .CRD (CRD), .CHIT (CHIT)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        mwr;
        logic        moe;
        logic [31:0] adr;
        logic [31:0] mwd;
        logic        chk;
        logic [31:0] crd;
        logic        chit;
    } vec_t;

    vec_t vecs[$];

    // Reference model state
    int unsigned m_mem [int];
    bit          m_valid [NL];
    int unsigned m_tag [NL];
    int unsigned m_data [NL];
    int unsigned m_crd;
    bit          m_chit;

    task automatic add(input logic r, input logic w, input logic o, input logic [31:0] a,
                       input logic [31:0] d, input logic c, input logic [31:0] ec, input logic eh);
        vec_t v;
        v.rst = r; v.mwr = w; v.moe = o; v.adr = a; v.mwd = d;
        v.chk = c; v.crd = ec; v.chit = eh;
        vecs.push_back(v);
    endtask

    task automatic step(input logic r, input logic w, input logic o,
                        input logic [31:0] a, input logic [31:0] d);
        rst = r; MWR = w; MOE = o; Adr = a; MWD = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] ec, input logic eh);
        checks++;
        if (CRD === ec) passes++;
        else $display("FAIL %s CRD got %h want %h", name, CRD, ec);
        checks++;
        if (CHIT === eh) passes++;
        else $display("FAIL %s CHIT got %b want %b", name, CHIT, eh);
    endtask

    // Higher-level model: index/tag/memory word from division and modulo.
    task automatic model(input logic r, input logic w, input logic o,
                         input logic [31:0] a, input logic [31:0] d);
        int unsigned word, idx, tg, ma;
        bit hit;
        word = a / 4;
        idx  = word % NL;
        tg   = word / NL;
        ma   = word % MW;
        if (r) begin
            for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
            m_crd = 0; m_chit = 1'b0;
        end else if (w) begin
            m_mem[ma] = d;
            m_valid[idx] = 1'b1; m_tag[idx] = tg; m_data[idx] = d;
            m_chit = 1'b0;
        end else if (o) begin
            hit    = m_valid[idx] && (m_tag[idx] == tg);
            m_crd  = hit ? m_data[idx] : m_mem[ma];
            m_chit = hit;
            m_valid[idx] = 1'b1; m_tag[idx] = tg; m_data[idx] = m_crd;
        end else begin
            m_chit = 1'b0;
        end
    endtask

    initial begin
        int unsigned pool [32];
        int unsigned a, d;
        int unsigned sel;
        bit r, w, o;

        // reset state
        add(1, 0, 0, 32'h0,   32'h0,         1, 32'h0,         0);
        // write-then-read hit
        add(0, 1, 0, 32'd120, 32'd1,         1, 32'h0,         0);
        add(0, 0, 1, 32'd120, 32'h0,         1, 32'd1,         1);
        // non-conflicting writes
        add(0, 1, 0, 32'd120, 32'd1,         1, 32'd1,         0);
        add(0, 1, 0, 32'd110, 32'd1,         1, 32'd1,         0);
        add(0, 0, 1, 32'd120, 32'h0,         1, 32'd1,         1);
        // conflict eviction at index 0
        add(0, 1, 0, 32'h40,  32'hAAAA_5555, 1, 32'd1,         0);
        add(0, 1, 0, 32'h440, 32'h1234_5678, 1, 32'd1,         0);
        add(0, 0, 1, 32'h40,  32'h0,         1, 32'hAAAA_5555, 0);
        add(0, 0, 1, 32'h40,  32'h0,         1, 32'hAAAA_5555, 1);
        add(0, 0, 1, 32'h440, 32'h0,         1, 32'h1234_5678, 0);
        // reset clears validity but not memory
        add(0, 1, 0, 32'h8,   32'hDEAD_BEEF, 1, 32'h1234_5678, 0);
        add(1, 0, 0, 32'h8,   32'h0,         1, 32'h0,         0);
        add(0, 0, 1, 32'h8,   32'h0,         1, 32'hDEAD_BEEF, 0);
        add(0, 0, 1, 32'h8,   32'h0,         1, 32'hDEAD_BEEF, 1);
        // write priority, then idle hold
        add(0, 1, 1, 32'h10,  32'd5,         1, 32'hDEAD_BEEF, 0);
        add(0, 0, 0, 32'h10,  32'h0,         1, 32'hDEAD_BEEF, 0);
        add(0, 0, 0, 32'h10,  32'h0,         1, 32'hDEAD_BEEF, 0);
        add(0, 0, 0, 32'h10,  32'h0,         1, 32'hDEAD_BEEF, 0);
        add(0, 0, 1, 32'h10,  32'h0,         1, 32'd5,         1);
        // byte offset ignored
        add(0, 1, 0, 32'h13,  32'd7,         1, 32'd5,         0);
        add(0, 0, 1, 32'h10,  32'h0,         1, 32'd7,         1);
        // write sampled during reset is dropped; first read after reset misses
        add(1, 1, 0, 32'h10,  32'd99,        1, 32'h0,         0);
        add(0, 0, 1, 32'h10,  32'h0,         1, 32'd7,         0);
        add(0, 0, 1, 32'h10,  32'h0,         1, 32'd7,         1);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].mwr, vecs[i].moe, vecs[i].adr, vecs[i].mwd);
            if (vecs[i].chk) check($sformatf("vec%0d", i), vecs[i].crd, vecs[i].chit);
        end

        // Random phase: small address pool with memory aliasing; preload all words.
        step(1, 0, 0, 32'h0, 32'h0);
        model(1, 0, 0, 32'h0, 32'h0);
        for (int i = 0; i < 32; i++)
            pool[i] = ($urandom_range(0, 63) + MW * $urandom_range(0, 3)) * 4;
        for (int i = 0; i < 32; i++) begin
            d = $urandom;
            step(0, 1, 0, pool[i], d);
            model(0, 1, 0, pool[i], d);
        end
        check("preload", m_crd, m_chit);

        for (int n = 0; n < 400; n++) begin
            a   = pool[$urandom_range(0, 31)] | $urandom_range(0, 3);
            d   = $urandom;
            sel = $urandom_range(0, 39);
            r   = (sel == 0);
            w   = (sel >= 1 && sel <= 12);
            o   = (sel >= 7);
            step(r, w, o, a, d);
            model(r, w, o, a, d);
            check($sformatf("rand%0d", n), m_crd, m_chit);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/cache.md
CACHE -- requirements
Module: cache

Interface
REQ-001 The block SHALL have parameter NUM_LINES, default 16, giving the number of direct-mapped one-word cache lines (power of two).
REQ-002 The block SHALL have parameter MEM_WORDS, default 1024, giving the number of 32-bit words in the backing memory (power of two).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port MWR, input, 1 bit: memory write request.
REQ-006 The block SHALL have port MOE, input, 1 bit: memory output enable, which is the read request.
REQ-007 The block SHALL have port Adr, input, 32 bits: byte address.
REQ-008 The block SHALL have port MWD, input, 32 bits: write data.
REQ-009 The block SHALL have port CRD, output, 32 bits: cache read data.
REQ-010 The block SHALL have port CHIT, output, 1 bit: high for one cycle after a read that hit.

Function
REQ-011 The block SHALL ignore Adr[1:0], so that all accesses are word-aligned.
REQ-012 The block SHALL decode the address as follows:
- word address = Adr[31:2];
- index = low log2(NUM_LINES) bits of the word address (Adr[5:2] at default);
- tag = Adr[31:2+log2(NUM_LINES)].
REQ-013 The block SHALL index the backing memory with the low log2(MEM_WORDS) bits of the word address, so that higher addresses alias.
REQ-014 Each cache line SHALL hold a valid bit, a tag and one 32-bit data word.
REQ-015 Hit SHALL mean that the indexed line is valid and its stored tag equals the tag of Adr.
REQ-016 When MWR=1 at a rising edge, the block SHALL perform a write-through with write-allocate:
- write MWD to the backing memory;
- set the indexed line to valid=1, tag=Adr tag, data=MWD, regardless of hit or miss.
REQ-017 A write SHALL leave CRD unchanged and SHALL drive CHIT=0 in the next cycle.
REQ-018 When MOE=1 and MWR=0 at a rising edge with a hit, the block SHALL register the line data into CRD and set CHIT=1.
REQ-019 When MOE=1 and MWR=0 at a rising edge with a miss, the block SHALL:
- register the backing-memory word into CRD;
- set CHIT=0;
- fill the indexed line (valid=1, tag, data) with that word.
REQ-020 Read latency SHALL be exactly one clock: CRD is valid after the edge that sampled the request.
REQ-021 When MWR=1 and MOE=1 together, the block SHALL treat the access as a write only.
REQ-022 When MWR=0 and MOE=0, the block SHALL leave all state unchanged, hold CRD, and set CHIT=0.
REQ-023 A read in the cycle after a write to the same address SHALL return the newly written data (hit).
REQ-024 A write to an index already holding another tag SHALL evict that line silently; no write-back is required because the cache is write-through.
REQ-025 Back-to-back accesses every cycle SHALL be supported, with no stall or busy signal.

Reset
REQ-026 While rst=1, the block SHALL:
- clear all valid bits;
- drive CRD=32'h0 and CHIT=0;
- ignore MWR and MOE.
REQ-027 Reset SHALL NOT clear backing-memory contents or cache tag and data arrays.
REQ-028 Asserting rst mid-operation SHALL abort any access sampled in that cycle, and the first read after reset SHALL miss.

Structure
REQ-029 A shared package SHALL hold the default NUM_LINES and MEM_WORDS values, the derived index and tag widths, and the address-field bit positions.
REQ-030 The backing memory SHALL be a sub-module named cache_mem with one synchronous write port and a combinational read port; the tag, valid and data arrays, the hit logic and the CRD/CHIT registers remain in cache.

Verification
REQ-031 Write-then-read hit: after reset, write Adr=120 with MWD=1, then read Adr=120 -> CRD=1, CHIT=1 one cycle later.
REQ-032 Non-conflicting write: write 120 with MWD=1, write 110 with MWD=1 (index 11, no conflict), then read 120 -> CRD=1, CHIT=1.
REQ-033 Conflict eviction, default parameters:
- write Adr=0x40 with 0xAAAA_5555, then write Adr=0x440 with 0x1234_5678 (same index 0, different tag);
- read 0x40 -> CRD=0xAAAA_5555, CHIT=0 (miss, filled from memory);
- immediate re-read of 0x40 -> CHIT=1.
REQ-034 Reset clears validity: write 0x8 with 0xDEAD_BEEF, pulse rst, then read 0x8 -> CRD=0xDEAD_BEEF, CHIT=0; the next read of 0x8 -> CHIT=1.
REQ-035 Write priority and idle hold: MWR=MOE=1 at Adr 0x10 with data 5 -> CRD unchanged; then MWR=MOE=0 for 3 cycles -> CRD held and CHIT=0; then read 0x10 -> CRD=5.
REQ-036 Byte offset ignored: write Adr=0x13 with 7, then read Adr=0x10 -> CRD=7, CHIT=1.
